// File: rtl/trng_pkg.sv
// Shared state encoding and default sizing for the TRNG sequencer.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    HOLD,
    FAULT
  } trng_state_e;

  localparam int TRNG_WORD_W    = 8;
  localparam int TRNG_WARMUP    = 16;
  localparam int TRNG_REP_LIMIT = 32;

endpackage

// File: rtl/vn_pair_filter.sv
// Von Neumann pair extractor over non-overlapping sample pairs.
// Accept strobe is combinational on the second sample of a differing pair; no backpressure.
module vn_pair_filter (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic bit_in,
  output logic acc,
  output logic acc_bit
);

  logic phase_q;
  logic first_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      phase_q <= 1'b0;
      first_q <= 1'b0;
    end else if (clr) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      if (!phase_q) first_q <= bit_in;
    end
  end

  // 10 yields 1, 01 yields 0; equal pairs are dropped
  assign acc     = phase_q & ~clr & (bit_in ^ first_q);
  assign acc_bit = first_q;

endmodule

// File: rtl/trng_seq_ctrl.sv
// Ring-oscillator sequencer: warm-up, Von Neumann extraction, word packing, repetition-count health test.
// First word valid WARMUP+2*WORD_W cycles after start; word is held in HOLD until valid&ready.
module trng_seq_ctrl
  import trng_pkg::*;
#(
  parameter int WORD_W    = TRNG_WORD_W,
  parameter int WARMUP    = TRNG_WARMUP,
  parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              raw_bit,
  input  logic              ready,
  input  logic              clear_fault,
  output logic              osc_en,
  output logic [WORD_W-1:0] word_out,
  output logic              valid,
  output logic              busy,
  output logic              fault
);

  localparam int WCNT_W = $clog2(WARMUP + 1);
  localparam int BCNT_W = $clog2(WORD_W + 1);
  localparam int RCNT_W = $clog2(REP_LIMIT + 1);

  trng_state_e state_q, state_d;

  logic [WCNT_W-1:0] warm_q;
  logic [BCNT_W-1:0] bit_q;
  logic [RCNT_W-1:0] rep_q, rep_nxt;
  logic              prev_q;
  // Holds the WORD_W-1 most recent accepted bits; the last bit joins directly at completion
  logic [WORD_W-2:0] sr_q;
  logic [WORD_W-1:0] word_q;

  logic in_collect, stay_collect;
  logic acc, acc_bit;
  logic warm_done, rep_trip, word_done, xfer;

  vn_pair_filter u_vn (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr     (~in_collect),
    .bit_in  (raw_bit),
    .acc     (acc),
    .acc_bit (acc_bit)
  );

  assign in_collect   = (state_q == COLLECT);
  assign stay_collect = in_collect && (state_d == COLLECT);
  assign warm_done    = (warm_q == WCNT_W'(WARMUP - 1));
  assign rep_nxt      = (rep_q == '0 || raw_bit != prev_q) ? RCNT_W'(1) : rep_q + RCNT_W'(1);
  assign rep_trip     = in_collect && (rep_nxt == RCNT_W'(REP_LIMIT));
  assign word_done    = acc && (bit_q == BCNT_W'(WORD_W - 1));
  assign xfer         = (state_q == HOLD) && ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:            if (start) state_d = trng_pkg::WARMUP;
      trng_pkg::WARMUP: begin
        if (!start)         state_d = IDLE;
        else if (warm_done) state_d = COLLECT;
      end
      COLLECT: begin
        if (rep_trip)       state_d = FAULT;
        else if (!start)    state_d = IDLE;
        else if (word_done) state_d = HOLD;
      end
      HOLD:            if (xfer) state_d = start ? COLLECT : IDLE;
      FAULT:           if (clear_fault) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    osc_en = 1'b0;
    valid  = 1'b0;
    busy   = 1'b0;
    fault  = 1'b0;
    case (state_q)
      trng_pkg::WARMUP, COLLECT: begin
        osc_en = 1'b1;
        busy   = 1'b1;
      end
      HOLD: begin
        osc_en = 1'b1;
        busy   = 1'b1;
        valid  = 1'b1;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      warm_q <= '0;
      bit_q  <= '0;
      rep_q  <= '0;
      prev_q <= 1'b0;
      sr_q   <= '0;
      word_q <= '0;
    end else begin
      warm_q <= (state_q == trng_pkg::WARMUP && state_d == trng_pkg::WARMUP)
                ? warm_q + WCNT_W'(1) : '0;
      if (!stay_collect) bit_q <= '0;
      else if (acc)      bit_q <= bit_q + BCNT_W'(1);
      rep_q <= stay_collect ? rep_nxt : '0;
      if (in_collect) prev_q <= raw_bit;
      if (in_collect && acc) sr_q <= {acc_bit, sr_q[WORD_W-2:1]};
      if (in_collect && state_d == HOLD) word_q <= {acc_bit, sr_q};
    end
  end

  assign word_out = word_q;

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Directed plus randomized bench for trng_seq_ctrl with a stream-level reference model.
module tb_trng_seq_ctrl;

  localparam int W   = 8;
  localparam int WU  = 16;
  localparam int RL  = 32;

  logic         clk = 1'b0;
  logic         rst_b, start, raw_bit, ready, clear_fault;
  logic         osc_en, valid, busy, fault;
  logic [W-1:0] word_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit stim_q[$];

  trng_seq_ctrl dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .raw_bit     (raw_bit),
    .ready       (ready),
    .clear_fault (clear_fault),
    .osc_en      (osc_en),
    .word_out    (word_out),
    .valid       (valid),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scan the collected samples: runs of equal samples trip at RL, pairs feed a Von Neumann word.
  // kind: 0 nothing, 1 word complete, 2 fault; idx is the sample on which it happens.
  function automatic void model(output int kind, output int idx, output logic [W-1:0] word);
    int run = 0;
    int nacc = 0;
    kind = 0;
    idx  = stim_q.size() - 1;
    word = '0;
    for (int i = 0; i < stim_q.size(); i++) begin
      run = (i > 0 && stim_q[i] == stim_q[i-1]) ? run + 1 : 1;
      if (run == RL) begin
        kind = 2; idx = i; return;
      end
      if (i % 2 == 1 && stim_q[i] != stim_q[i-1]) begin
        word[nacc] = stim_q[i-1];
        nacc++;
        if (nacc == W) begin
          kind = 1; idx = i; return;
        end
      end
    end
  endfunction

  task automatic push_pair(input logic [1:0] p);
    stim_q.push_back(p[1]);
    stim_q.push_back(p[0]);
  endtask

  task automatic gen_rand(input int n, input bit sticky);
    stim_q.delete();
    for (int i = 0; i < n; i++) begin
      if (sticky && i > 0 && $urandom_range(15, 0) != 0) stim_q.push_back(stim_q[i-1]);
      else stim_q.push_back(1'($urandom_range(1, 0)));
    end
  endtask

  // From IDLE: start edge becomes edge 0, then WU warm-up cycles with ignored raw bits.
  task automatic warmup(input string tag);
    start = 1'b1;
    raw_bit = 1'($urandom);
    step();
    cyc = 0;
    chk({tag, " osc_en c1"}, osc_en, 1);
    chk({tag, " busy c1"}, busy, 1);
    for (int i = 0; i < WU; i++) begin
      raw_bit = 1'($urandom);
      step();
      chk({tag, " warm no valid"}, {valid, fault}, 0);
    end
  endtask

  task automatic run_collect(input string tag, output int kind);
    int idx;
    logic [W-1:0] w;
    model(kind, idx, w);
    for (int i = 0; i <= idx; i++) begin
      raw_bit = stim_q[i];
      step();
      if (i < idx) chk({tag, " early"}, {valid, fault}, 0);
    end
    if (kind == 2) begin
      chk({tag, " fault"}, fault, 1);
      chk({tag, " fault osc_en"}, osc_en, 0);
      chk({tag, " fault valid"}, valid, 0);
    end else begin
      chk({tag, " valid"}, valid, 1);
      chk({tag, " word"}, word_out, w);
      chk({tag, " osc_en"}, osc_en, 1);
    end
  endtask

  initial begin
    logic [1:0] basic[8];
    logic [1:0] disc[10];
    logic [W-1:0] held;
    int kind;
    basic = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
    disc  = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10};

    // reset with random inputs
    rst_b = 1'b0; start = 1'b0; raw_bit = 1'b0; ready = 1'b0; clear_fault = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); raw_bit = 1'($urandom); ready = 1'($urandom); clear_fault = 1'($urandom);
      step();
      chk("reset outs", {osc_en, valid, busy, fault}, 0);
      chk("reset word", word_out, 0);
    end
    start = 1'b0; ready = 1'b0; clear_fault = 1'b0;
    rst_b = 1'b1;
    step(); step();
    chk("idle after reset", {osc_en, busy}, 0);

    // basic word 0xA5 at edge 32
    stim_q.delete();
    foreach (basic[i]) push_pair(basic[i]);
    warmup("basic");
    run_collect("basic", kind);
    chk("basic word A5", word_out, 8'hA5);
    chk("basic edge", cyc, 32);
    ready = 1'b1; start = 1'b0;
    step();
    ready = 1'b0;
    chk("basic xfer idle", {valid, busy}, 0);
    chk("word kept", word_out, 8'hA5);

    // discarded pairs push completion to edge 36
    stim_q.delete();
    foreach (disc[i]) push_pair(disc[i]);
    warmup("disc");
    run_collect("disc", kind);
    chk("disc word A5", word_out, 8'hA5);
    chk("disc edge", cyc, 36);

    // backpressure in HOLD, then back-to-back word
    held = word_out;
    for (int i = 0; i < 10; i++) begin
      raw_bit = 1'($urandom);
      step();
      chk("bp valid", valid, 1);
      chk("bp word", word_out, held);
    end
    ready = 1'b1; start = 1'b1;
    step();
    cyc = 0;
    ready = 1'b0;
    chk("b2b collect", {valid, busy}, 2'b01);
    stim_q.delete();
    for (int i = 0; i < W; i++) push_pair(2'b10);
    run_collect("b2b", kind);
    chk("b2b word FF", word_out, 8'hFF);
    chk("b2b edge", cyc, 16);
    ready = 1'b1; start = 1'b0;
    step();
    ready = 1'b0;

    // stuck source trips the health test on the 32nd sample
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back(1'b1);
    warmup("stuck");
    run_collect("stuck", kind);
    chk("stuck kind", kind, 2);
    chk("stuck edge", cyc, WU + RL);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault held", {fault, busy, osc_en}, 3'b100);
    end
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("cleared", {fault, busy}, 0);
    step();
    chk("rewarm", {busy, osc_en}, 2'b11);
    start = 1'b0;
    step();
    chk("rewarm abort", busy, 0);

    // abort after 3 accepted bits, restart from fresh bits
    warmup("abort");
    for (int i = 0; i < 3; i++) begin
      raw_bit = 1'b1; step();
      raw_bit = 1'b0; step();
    end
    start = 1'b0; raw_bit = 1'($urandom);
    step();
    chk("abort idle", {valid, busy}, 0);
    gen_rand(200, 1'b0);
    warmup("restart");
    run_collect("restart", kind);

    // asynchronous reset while holding a word
    #2;
    rst_b = 1'b0;
    #1;
    chk("hold rst valid", valid, 0);
    chk("hold rst word", word_out, 0);
    start = 1'b0;
    step();
    rst_b = 1'b1;
    step();

    // random streams, some biased towards long runs
    for (int t = 0; t < 8; t++) begin
      gen_rand(300, t % 2 == 1);
      warmup("rand");
      run_collect("rand", kind);
      start = 1'b0;
      if (kind == 2) clear_fault = 1'b1;
      else           ready = 1'b1;
      step();
      clear_fault = 1'b0; ready = 1'b0;
      chk("rand back idle", {valid, busy, fault}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
